axis_fifo: RTL

AXIS_FIFO -- requirements
Module: axis_fifo

---
 rtl/axis_fifo.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/axis_fifo.sv
// -----------------------------------------------------------------------------
// axis_fifo -- synchronous AXI4-Stream FIFO, first-word-fall-through output.
//
// Parameters
//    DATA_WIDTH  tdata width in bits (default 64)
//    DEPTH       number of storage entries, power of two, >= 2 (default 16)
//
// Ports
//    aclk            single clock, everything on its rising edge
//    areset          synchronous active-high reset
//    s_axis_tdata    upstream data beat
//    s_axis_tvalid   upstream beat valid
//    s_axis_tlast    upstream last beat of packet
//    s_axis_tready   registered: FIFO will accept a beat at the next edge
//    m_axis_tdata    downstream data beat (entry at the read pointer)
//    m_axis_tvalid   downstream beat valid
//    m_axis_tlast    downstream last beat of packet
//    m_axis_tready   downstream accepts a beat
//    count           number of stored beats (0 .. DEPTH)
//
// Build option
//    AXIS_FIFO_PACKET_MODE_EN  store-and-forward: m_axis_tvalid is held off
//    until a complete packet (tlast) is stored, or the FIFO is full, the
//    latter letting packets longer than DEPTH cut through instead of
//    deadlocking. Undefined (default): plain FIFO, valid whenever non-empty.
// -----------------------------------------------------------------------------
module axis_fifo #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 16
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic                      s_axis_tvalid,
   input  logic                      s_axis_tlast,
   output logic                      s_axis_tready,
   output logic [DATA_WIDTH-1:0]     m_axis_tdata,
   output logic                      m_axis_tvalid,
   output logic                      m_axis_tlast,
   input  logic                      m_axis_tready,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int AW = $clog2(DEPTH);   // entry address width
   localparam int PW = AW + 1;          // pointer width, extra wrap bit
   localparam int EW = DATA_WIDTH + 1;  // stored entry: {tlast, tdata}

   logic [EW-1:0] mem [DEPTH];

   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [PW-1:0] rd_ptr_next;
   logic [PW-1:0] count_reg;
   logic [PW-1:0] count_next;
   logic          s_ready_reg;
   logic [EW-1:0] out_reg;
   logic          wr_en;
   logic          rd_en;
   logic          bypass;

   assign wr_en = s_axis_tvalid & s_ready_reg;
   assign rd_en = m_axis_tvalid & m_axis_tready;

   assign rd_ptr_next = rd_ptr_reg + PW'(rd_en);

   always_comb begin
      count_next = count_reg;
      case ({wr_en, rd_en})
         2'b10:   count_next = count_reg + PW'(1);
         2'b01:   count_next = count_reg - PW'(1);
         default: count_next = count_reg;
      endcase
   end

   // Storage array: write port only, so it maps onto block RAM.
   always_ff @(posedge aclk) begin
      if (wr_en) begin
         mem[wr_ptr_reg[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
      end
   end

   // Registered read addressed by the *next* read pointer so the head entry
   // is already on m_axis when the pointer lands on it. The only way the
   // next head can be the slot being written this edge is when the FIFO is
   // (or is about to become) empty; the incoming beat is forwarded then,
   // which gives the one-cycle write-to-output latency.
   assign bypass = wr_en && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]);

   always_ff @(posedge aclk) begin
      if (bypass) begin
         out_reg <= {s_axis_tlast, s_axis_tdata};
      end else begin
         out_reg <= mem[rd_ptr_next[AW-1:0]];
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         s_ready_reg <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         rd_ptr_reg  <= rd_ptr_next;
         count_reg   <= count_next;
         // Ready looks at the occupancy after this edge, so a read from
         // full reopens the input on the very next cycle.
         s_ready_reg <= (count_next < PW'(DEPTH));
      end
   end

`ifdef AXIS_FIFO_PACKET_MODE_EN
   logic [PW-1:0] pkt_cnt_reg;
   logic          full;
   logic          wr_last;
   logic          rd_last;

   // Pointers equal except for the wrap bit: every entry is occupied.
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign wr_last = wr_en & s_axis_tlast;
   assign rd_last = rd_en & out_reg[DATA_WIDTH];

   // Number of complete packets held (tlast beats in storage).
   always_ff @(posedge aclk) begin
      if (areset) begin
         pkt_cnt_reg <= '0;
      end else begin
         case ({wr_last, rd_last})
            2'b10:   pkt_cnt_reg <= pkt_cnt_reg + PW'(1);
            2'b01:   pkt_cnt_reg <= pkt_cnt_reg - PW'(1);
            default: pkt_cnt_reg <= pkt_cnt_reg;
         endcase
      end
   end

   assign m_axis_tvalid = (count_reg != '0) && ((pkt_cnt_reg != '0) || full);
`else
   assign m_axis_tvalid = (count_reg != '0);
`endif

   assign s_axis_tready = s_ready_reg;
   assign m_axis_tdata  = out_reg[DATA_WIDTH-1:0];
   assign m_axis_tlast  = out_reg[DATA_WIDTH];
   assign count         = count_reg;

endmodule
